// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding,
// default widths and the width of the speed selector.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 4;
  localparam int DIV_W_DEF = 27;
  localparam int SPEED_W   = 2;

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// Programmable tick divider. It produces a one-cycle clock-enable pulse
// every 'term' cycles while running. The divider count freezes while not
// running and is zeroed on clear. 'term' is taken from speed_sel only at a
// tick boundary or while load is high, so a speed change never cuts a
// period short.
module tick_gen
  import count_seq_pkg::*;
#(
  parameter int DIV_DEFAULT = 100_000_000,
  parameter int DIV_W       = DIV_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clear,
  input  logic               load,
  input  logic [SPEED_W-1:0] speed_sel,
  output logic               step,
  output logic               tick
);

  localparam logic [DIV_W:0] DIV_FULL = (DIV_W+1)'(DIV_DEFAULT);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W:0]   term;
  logic [DIV_W:0]   term_sel;

  assign term_sel = DIV_FULL >> speed_sel;
  assign step     = run && !clear && ({1'b0, div_cnt} == (term - 1'b1));

  // Divider count, latched period and the registered tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      term    <= DIV_FULL;
      tick    <= 1'b0;
    end else begin
      tick <= step;
      if (clear || step) begin
        div_cnt <= '0;
      end else if (run) begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (load || step) begin
        term <= term_sel;
      end
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Count sequencer: direction/run FSM plus the up/down counter it drives,
// paced by the tick_gen divider. Buttons are single-cycle pulses with
// priority clear > hold > up/down; up and down together cancel out.
// Optional build macro COUNT_SEQUENCER_SATURATE_EN: the counter saturates
// at its limits instead of wrapping, and reaching a limit parks the FSM
// in HOLD.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int DIV_DEFAULT = 100_000_000,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_hold,
  input  logic               btn_clear,
  input  logic [SPEED_W-1:0] speed_sel,
  output logic [CNT_W-1:0]   count,
  output logic               dir,
  output logic               running,
  output logic               tick,
  output logic               wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic             saved_dir;
  logic             saved_dir_next;
  logic [CNT_W-1:0] count_next;
  logic             wrap_next;
  logic             step;
  logic             up_req;
  logic             down_req;
  logic             in_idle;
`ifdef COUNT_SEQUENCER_SATURATE_EN
  logic             sat_hit;
`endif

  assign running  = (state == UP) || (state == DOWN);
  assign in_idle  = (state == IDLE);
  assign up_req   = btn_up && !btn_down;
  assign down_req = btn_down && !btn_up;
  assign dir      = saved_dir;

  tick_gen #(
    .DIV_DEFAULT(DIV_DEFAULT),
    .DIV_W      (DIV_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (reset),
    .run      (running),
    .clear    (btn_clear || in_idle),
    .load     (in_idle),
    .speed_sel(speed_sel),
    .step     (step),
    .tick     (tick)
  );

  // Counter arithmetic for the coming edge: clear, or one step per tick.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
`ifdef COUNT_SEQUENCER_SATURATE_EN
    sat_hit    = 1'b0;
`endif
    if (btn_clear) begin
      count_next = CNT_ZERO;
    end else if (step) begin
      if (state == UP) begin
`ifdef COUNT_SEQUENCER_SATURATE_EN
        if (count != CNT_MAX) begin
          count_next = count + 1'b1;
        end
        wrap_next = (count == (CNT_MAX - CNT_ONE));
        sat_hit   = (count >= (CNT_MAX - CNT_ONE));
`else
        count_next = count + 1'b1;
        wrap_next  = (count == CNT_MAX);
`endif
      end else begin
`ifdef COUNT_SEQUENCER_SATURATE_EN
        if (count != CNT_ZERO) begin
          count_next = count - 1'b1;
        end
        wrap_next = (count == CNT_ONE);
        sat_hit   = (count <= CNT_ONE);
`else
        count_next = count - 1'b1;
        wrap_next  = (count == CNT_ZERO);
`endif
      end
    end
  end

  // Next-state logic for the run/direction FSM.
  always_comb begin
    state_next     = state;
    saved_dir_next = saved_dir;
    if (btn_clear) begin
      state_next = IDLE;
`ifdef COUNT_SEQUENCER_SATURATE_EN
    end else if (sat_hit) begin
      state_next = HOLD;
`endif
    end else if (btn_hold) begin
      case (state)
        UP, DOWN: state_next = HOLD;
        HOLD:     state_next = saved_dir ? UP : DOWN;
        default:  state_next = state;
      endcase
    end else if (up_req) begin
      state_next     = UP;
      saved_dir_next = 1'b1;
    end else if (down_req) begin
      state_next     = DOWN;
      saved_dir_next = 1'b0;
    end
  end

  // State, direction, counter and wrap registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      saved_dir <= 1'b1;
      count     <= '0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_next;
      saved_dir <= saved_dir_next;
      count     <= count_next;
      wrap      <= wrap_next;
    end
  end

endmodule
